// File: rtl/register_dump_reader.sv
// rtl/register_dump_reader.sv - sequential register-file dump engine with XOR checksum
module register_dump_reader #(
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start_i,
    output logic [4:0]  Read_Register_o,
    input  logic [31:0] Read_Data_i,
    output logic [31:0] Dump_Data_o,
    output logic [4:0]  Dump_Index_o,
    output logic        Dump_Valid_o,
    input  logic        Dump_Ready_i,
    output logic [31:0] Checksum_o,
    output logic        Busy_o,
    output logic        Done_o
);

    localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
    localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [4:0] idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (Start_i) state_next = READ;
            READ: state_next = SEND;
            SEND: begin
                if (Dump_Ready_i) begin
                    state_next = (idx == LAST_IDX) ? DONE : READ;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        Busy_o       = (state != IDLE);
        Done_o       = (state == DONE);
        Dump_Valid_o = (state == SEND);
    end

    assign Read_Register_o = idx;

    // End-of-range is tested before the increment so LAST_REG=31 never wraps idx.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx          <= FIRST_IDX;
            Dump_Data_o  <= '0;
            Dump_Index_o <= '0;
            Checksum_o   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start_i) begin
                        idx        <= FIRST_IDX;
                        Checksum_o <= '0;
                    end
                end
                READ: begin
                    Dump_Data_o  <= Read_Data_i;
                    Dump_Index_o <= idx;
                end
                SEND: begin
                    if (Dump_Ready_i) begin
                        Checksum_o <= Checksum_o ^ Dump_Data_o;
                        if (idx != LAST_IDX) begin
                            idx <= idx + 5'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
